// File: rtl/sramlike_pkg.sv
// Shared definitions for the sram-like bus: arbiter state/owner encodings and
// the transfer-size codes also used by the SRAM-to-sram-like adapters.
package sramlike_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_DATA = 1'b0,
        OWN_INST = 1'b1
    } owner_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Request-side payload of one sram-like master, muxed as a unit.
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sl_req_t;

endpackage

// File: rtl/sramlike_starve_ctr.sv
// Saturating count of consecutive data grants accepted while inst is waiting;
// force_inst hands the next contested grant to the instruction side.
module sramlike_starve_ctr
    import sramlike_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic accept,
    input  logic grant_inst,
    input  logic inst_req,
    output logic force_inst
);

    localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

    logic [3:0] streak_q;
    logic [3:0] streak_d;

    always_comb begin
        streak_d = streak_q;
        if (accept) begin
            if (grant_inst || !inst_req) begin
                streak_d = 4'd0;
            end else if (streak_q < Limit) begin
                streak_d = streak_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q <= 4'd0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign force_inst = (streak_q == Limit);

endmodule

// File: rtl/sramlike_arbiter.sv
// Two-master (inst/data) to one-slave sram-like arbiter, one transaction in flight,
// data-priority with bounded starvation of instruction fetch.
module sramlike_arbiter
    import sramlike_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    arb_state_e state_q;
    owner_e     owner_q;

    logic    any_req;
    logic    force_inst;
    logic    grant_active;
    logic    accept;
    logic    fwd_data_ok;
    owner_e  sel;
    owner_e  grant;
    sl_req_t inst_bus;
    sl_req_t data_bus;
    sl_req_t grant_bus;

    assign inst_bus = {inst_wr, inst_size, inst_addr, inst_wdata};
    assign data_bus = {data_wr, data_size, data_addr, data_wdata};
    assign any_req  = inst_req | data_req;

    // Data wins a contested grant unless inst has been passed over STARVE_LIMIT times.
    assign sel   = (inst_req && (!data_req || force_inst)) ? OWN_INST : OWN_DATA;
    assign grant = (state_q == IDLE) ? sel : owner_q;

    assign grant_active = !rst && (((state_q == IDLE) && any_req) || (state_q == REQ));

    always_comb begin
        mem_req = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE:    mem_req = any_req;
                REQ:     mem_req = (owner_q == OWN_INST) ? inst_req : data_req;
                default: mem_req = 1'b0;
            endcase
        end
    end

    always_comb begin
        grant_bus = '0;
        if (grant_active) begin
            grant_bus = (grant == OWN_INST) ? inst_bus : data_bus;
        end
    end

    assign mem_wr    = grant_bus.wr;
    assign mem_size  = grant_bus.size;
    assign mem_addr  = grant_bus.addr;
    assign mem_wdata = grant_bus.wdata;

    assign accept = mem_req & mem_addr_ok;

    // A data_ok in IDLE only counts when it completes the request accepted this cycle.
    assign fwd_data_ok = !rst && mem_data_ok &&
                         ((state_q == REQ) || (state_q == WAIT) || accept);

    assign inst_addr_ok = accept & (grant == OWN_INST);
    assign data_addr_ok = accept & (grant == OWN_DATA);
    assign inst_data_ok = fwd_data_ok & (grant == OWN_INST);
    assign data_data_ok = fwd_data_ok & (grant == OWN_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_DATA;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q <= sel;
                        if (accept) begin
                            state_q <= mem_data_ok ? IDLE : WAIT;
                        end else begin
                            state_q <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (accept) begin
                        state_q <= mem_data_ok ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (mem_data_ok) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    sramlike_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk       (clk),
        .rst       (rst),
        .accept    (accept),
        .grant_inst(grant == OWN_INST),
        .inst_req  (inst_req),
        .force_inst(force_inst)
    );

endmodule

// File: tb/tb_sramlike_arbiter.sv
// Bench for sramlike_arbiter: directed scenarios then random traffic, all checked
// against a transaction-level model of who owns the bus and where acks go.
module tb_sramlike_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    sramlike_arbiter #(
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_req    (inst_req),
        .inst_wr     (inst_wr),
        .inst_size   (inst_size),
        .inst_addr   (inst_addr),
        .inst_wdata  (inst_wdata),
        .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_size   (data_size),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .data_rdata  (data_rdata),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_size    (mem_size),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: one pending transaction record (exists / accepted / who), plus the
    // number of data grants in a row that overtook a waiting inst request.
    bit m_busy, m_acc;
    int m_own;      // 0 = data, 1 = inst
    int m_streak;
    bit last_aok_i, last_aok_d;
    int dut_log[$]; // grants seen on the DUT's addr_ok outputs

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Check the current cycle against the model, then advance one clock.
    task automatic tick();
        bit any, act, e_req, acc_now, dok;
        int who;
        logic [31:0] e_addr, e_wdata;
        logic [1:0]  e_size;
        logic        e_wr;
        #2;
        any = (inst_req === 1'b1) || (data_req === 1'b1);
        if (m_busy) who = m_own;
        else who = (data_req && !(inst_req && m_streak == LIMIT)) ? 0 : 1;
        act   = !rst && (m_busy ? !m_acc : any);
        e_req = act && (m_busy ? ((who == 1) ? inst_req : data_req) : 1'b1);
        e_wr    = act ? ((who == 1) ? inst_wr    : data_wr)    : 1'b0;
        e_size  = act ? ((who == 1) ? inst_size  : data_size)  : 2'b00;
        e_addr  = act ? ((who == 1) ? inst_addr  : data_addr)  : 32'h0;
        e_wdata = act ? ((who == 1) ? inst_wdata : data_wdata) : 32'h0;
        acc_now = e_req && mem_addr_ok;
        dok     = !rst && mem_data_ok && (m_busy || acc_now);

        chk("mem_req",      mem_req,      e_req);
        chk("mem_wr",       mem_wr,       e_wr);
        chk("mem_size",     mem_size,     e_size);
        chk("mem_addr",     mem_addr,     e_addr);
        chk("mem_wdata",    mem_wdata,    e_wdata);
        chk("inst_addr_ok", inst_addr_ok, acc_now && who == 1);
        chk("data_addr_ok", data_addr_ok, acc_now && who == 0);
        chk("inst_data_ok", inst_data_ok, dok && who == 1);
        chk("data_data_ok", data_data_ok, dok && who == 0);
        chk("inst_rdata",   inst_rdata,   mem_rdata);
        chk("data_rdata",   data_rdata,   mem_rdata);

        if (inst_addr_ok === 1'b1) dut_log.push_back(1);
        if (data_addr_ok === 1'b1) dut_log.push_back(0);
        last_aok_i = acc_now && who == 1;
        last_aok_d = acc_now && who == 0;

        if (rst) begin
            m_busy = 0; m_acc = 0; m_own = 0; m_streak = 0;
        end else if (acc_now) begin
            if (who == 1 || !inst_req) m_streak = 0;
            else if (m_streak < LIMIT) m_streak++;
            m_own  = who;
            m_busy = !mem_data_ok;
            m_acc  = 1;
        end else if (!m_busy && e_req) begin
            m_busy = 1; m_acc = 0; m_own = who;
        end else if (m_busy && m_acc && mem_data_ok) begin
            m_busy = 0;
        end
        @(posedge clk);
        #1;
    endtask

    int exp_order[10];

    initial begin
        exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        m_busy = 0; m_acc = 0; m_own = 0; m_streak = 0;
        last_aok_i = 0; last_aok_d = 0;
        rst = 1;
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
        @(posedge clk); #1;
        tick();
        // Requests and slave strobes during reset must not leak out.
        inst_req = 1; data_req = 1; inst_addr = 32'h1234_5678; data_addr = 32'h9ABC_DEF0;
        mem_addr_ok = 1; mem_data_ok = 1;
        tick();
        rst = 0; inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
        tick();

        // Single read
        inst_req = 1; inst_addr = 32'hBFC0_0000; inst_size = 2'b10; inst_wr = 0;
        mem_addr_ok = 1;
        tick();
        inst_req = 0; mem_addr_ok = 0;
        tick();
        mem_data_ok = 1; mem_rdata = 32'h3C1A_0001;
        tick();
        mem_data_ok = 0;
        tick();

        // Simultaneous requests: data first, inst right after data_ok
        dut_log.delete();
        inst_req = 1; inst_addr = 32'hBFC0_0004;
        data_req = 1; data_wr = 1; data_addr = 32'h8000_1000; data_wdata = 32'hCAFE_F00D;
        data_size = 2'b10; mem_addr_ok = 1;
        tick();
        data_req = 0; mem_addr_ok = 0;
        tick();
        mem_data_ok = 1;
        tick();
        mem_data_ok = 0; mem_addr_ok = 1;
        tick();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        tick();
        mem_data_ok = 0;
        chk("simul_order_cnt", dut_log.size(), 2);
        if (dut_log.size() == 2) begin
            chk("simul_first",  dut_log[0], 0);
            chk("simul_second", dut_log[1], 1);
        end

        // Grant lock: data rises while inst waits for addr_ok
        dut_log.delete();
        inst_req = 1; inst_addr = 32'h1FC0_0010; data_wr = 0;
        tick();
        data_req = 1; data_addr = 32'h8000_2000;
        tick();
        tick();
        mem_addr_ok = 1;
        tick();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        tick();
        mem_data_ok = 0; mem_addr_ok = 1;
        tick();
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        tick();
        mem_data_ok = 0;
        chk("lock_order_cnt", dut_log.size(), 2);
        if (dut_log.size() == 2) begin
            chk("lock_first",  dut_log[0], 1);
            chk("lock_second", dut_log[1], 0);
        end

        // Starvation: both held, slave completes every grant in the same cycle
        rst = 1; tick(); rst = 0;
        dut_log.delete();
        inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
        repeat (10) tick();
        chk("starve_cnt", dut_log.size(), 10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("starve_grant%0d", i), (i < dut_log.size()) ? dut_log[i] : 2,
                exp_order[i]);
        end

        // Same-cycle addr_ok + data_ok, then a grant on the very next cycle
        inst_req = 0; data_req = 1;
        tick();
        dut_log.delete();
        data_req = 0; inst_req = 1; mem_data_ok = 0;
        tick();
        chk("same_cycle_next_grant", dut_log.size(), 1);
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        tick();
        mem_data_ok = 0;
        tick();

        // Reset in WAIT, then a stray data_ok
        data_req = 1; mem_addr_ok = 1;
        tick();
        data_req = 0; mem_addr_ok = 0;
        tick();
        rst = 1; inst_req = 1;
        tick();
        rst = 0; inst_req = 0; mem_data_ok = 1;
        tick();
        mem_data_ok = 0;
        tick();

        // Random traffic
        repeat (1500) begin
            bit any;
            if (inst_req && last_aok_i) inst_req = 0;
            if (data_req && last_aok_d) data_req = 0;
            if (!inst_req && $urandom_range(99) < 35) begin
                inst_req = 1; inst_addr = $urandom; inst_wr = 1'($urandom_range(1));
                inst_size = 2'($urandom_range(2)); inst_wdata = $urandom;
            end
            if (!data_req && $urandom_range(99) < 50) begin
                data_req = 1; data_addr = $urandom; data_wr = 1'($urandom_range(1));
                data_size = 2'($urandom_range(2)); data_wdata = $urandom;
            end
            rst = ($urandom_range(199) == 0);
            any = inst_req || data_req;
            mem_addr_ok = ($urandom_range(99) < 45);
            if (m_busy && m_acc)  mem_data_ok = ($urandom_range(99) < 40);
            else if (m_busy || any) mem_data_ok = mem_addr_ok && ($urandom_range(99) < 25);
            else                  mem_data_ok = ($urandom_range(99) < 10);
            mem_rdata = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sramlike_arbiter.md
# sramlike_arbiter

Two-master to one-slave arbiter for the sram-like bus. It merges the instruction-side and data-side sram-like request streams, produced by the SRAM-to-sram-like adapters, onto the single sram-like port that feeds the cache/AXI bridge. One transaction is outstanding at a time. Data has priority, with a bounded-starvation guarantee for instruction fetch.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while inst_req is pending; the next grant goes to inst. Range 1..15.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- inst_req / data_req  in  1  master request, held until that master's addr_ok.
- inst_wr / data_wr  in  1  1 = write.
- inst_size / data_size  in  2  00 byte, 01 half, 10 word.
- inst_addr / data_addr  in  32  byte address.
- inst_wdata / data_wdata  in  32  write data.
- inst_addr_ok / data_addr_ok  out  1  request accepted by the slave; forwarded to the owner only.
- inst_data_ok / data_data_ok  out  1  transaction complete; forwarded to the owner only.
- inst_rdata / data_rdata  out  32  read data, valid with the matching data_ok.
- mem_req  out  1  slave request.
- mem_wr / mem_size / mem_addr / mem_wdata  out  1/2/32/32  muxed from the granted master.
- mem_addr_ok  in  1  slave accepted the request.
- mem_data_ok  in  1  slave completed the request.
- mem_rdata  in  32  slave read data.

## Operation
- **States.**
  - IDLE: no grant held.
  - REQ: grant held, mem_req asserted, waiting for mem_addr_ok.
  - WAIT: request accepted, waiting for mem_data_ok.
- **IDLE.**
  - If any request is present, select the owner combinationally and drive mem_* from that owner in the same cycle.
  - Without mem_addr_ok, go to REQ. With mem_addr_ok, go to WAIT; if mem_data_ok is also high, go straight back to IDLE.
- **Selection rule.**
  - data_req only: data. inst_req only: inst.
  - Both requesting: data, unless streak == STARVE_LIMIT, in which case inst.
- **REQ.**
  - The grant is locked: owner and mux do not change even if the other master raises req.
  - mem_req mirrors the owner's req.
  - mem_addr_ok goes to WAIT, or to IDLE if mem_data_ok arrives in the same cycle.
- **WAIT.**
  - mem_req = 0.
  - mem_data_ok goes to IDLE.
  - A new grant may be issued in the cycle after returning to IDLE, never in the data_ok cycle itself.
- **Routing.**
  - owner_addr_ok = mem_addr_ok & (state grants owner).
  - owner_data_ok = mem_data_ok & (state ∈ {REQ, WAIT}) & owner.
  - Both rdata outputs = mem_rdata; qualified only by data_ok.
  - The non-owner never sees addr_ok or data_ok.
- **Stray responses.** mem_data_ok in IDLE, or mem_addr_ok with no grant, is ignored and never forwarded.
- **Streak counter (4 bits).**
  - On a data grant accepted (addr_ok) while inst_req = 1: streak + 1, saturating at STARVE_LIMIT.
  - On any inst grant accepted: 0.
  - On data accepted with inst_req = 0: 0.
- **Reset.**
  - state = IDLE, owner = data, streak = 0.
  - All outputs 0: mem_req, mem_wr, all addr_ok/data_ok, mem_size = 00, mem_addr = 0, mem_wdata = 0.
- **Reset mid-operation.** Asserting rst in REQ or WAIT abandons the transaction. No data_ok is forwarded afterwards; a late mem_data_ok arrives in IDLE and is dropped.

## Timing
- Request path is combinational: master req → mem_req with zero added latency in IDLE and REQ.
- mem_addr_ok → owner addr_ok is combinational, same cycle.
- mem_data_ok/mem_rdata → owner data_ok/rdata is combinational, same cycle.
- Registered state: state (2 bits), owner (1 bit), streak (4 bits).
- Back-to-back throughput: one transaction per (slave latency + 1) cycles; the cycle after data_ok is the earliest new grant.
- mem_wr/size/addr/wdata are stable from the mem_req rise until mem_addr_ok.

## Structure
- Shared package (sramlike_pkg):
  - state encoding: IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2;
  - owner encoding: OWN_DATA = 1'b0, OWN_INST = 1'b1;
  - size constants SZ_BYTE / SZ_HALF / SZ_WORD, shared with the SRAM-to-sram-like adapters.
- One sub-module: sramlike_starve_ctr. It holds the saturating streak counter and outputs force_inst (streak == STARVE_LIMIT).
- FSM, mux and routing stay in the top module.

## Test plan
- **Single read:**
  - stimulus: inst_req = 1, addr 0xBFC00000, size 10; slave gives addr_ok at cycle 0 and data_ok with rdata 0x3C1A0001 at cycle 2;
  - required: inst_addr_ok at cycle 0, inst_data_ok and inst_rdata = 0x3C1A0001 at cycle 2, data_* acks stay 0.
- **Simultaneous requests:**
  - stimulus: inst_req and data_req both high in IDLE, data_wr = 1, addr 0x80001000;
  - required: mem_addr = 0x80001000, mem_wr = 1; inst is granted in the cycle after data_data_ok.
- **Grant lock:**
  - stimulus: inst granted with mem_addr_ok held low 3 cycles; data_req rises in cycle 1;
  - required: mem_addr stays the inst address until addr_ok, and data is served afterwards.
- **Starvation:**
  - stimulus: STARVE_LIMIT = 4, inst_req and data_req held high continuously;
  - required: grant order is D, D, D, D, I, D, D, D, D, I.
- **Same-cycle addr_ok + data_ok:**
  - stimulus: slave returns both in the grant cycle;
  - required: owner gets both in that cycle, and state is back to IDLE on the next edge.
- **Reset in WAIT and stray data_ok:**
  - stimulus: assert rst while in WAIT, release it, then pulse mem_data_ok;
  - required: all outputs 0 during reset, and no data_ok is forwarded after release.
